// File: rtl/result_capture_fifo_pkg.sv
// Shared definitions for the result capture FIFO and the modular-exponentiation
// core it serves.
//   RSA_WIDTH : default result width (R_i / C_ex)
//   RSA_DEPTH : default number of queued results
package result_capture_fifo_pkg;

  localparam int RSA_WIDTH = 10;
  localparam int RSA_DEPTH = 4;

endpackage

// File: rtl/result_fifo_mem.sv
// Storage array for the result capture FIFO.
// One synchronous write port and one asynchronous read port; the array has no
// reset because the valid entries are tracked entirely by the pointer logic.
// Ports:
//   clk      : clock, rising edge
//   we       : write enable
//   wr_addr  : write slot
//   wr_data  : data written at wr_addr when we=1
//   rd_addr  : read slot
//   rd_data  : combinational contents of rd_addr
module result_fifo_mem #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/result_capture_fifo.sv
// Result capture FIFO: queues up to DEPTH modular-exponentiation results
// (each marked by en & eoc) and presents them first-word-fall-through on a
// valid/ready interface towards the readout side.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, discards all queued results
//   en       : block enable, gates capture only (pops still proceed)
//   eoc      : end-of-conversion strobe, one cycle per result
//   R_i      : core result, sampled only on a push
//   C_ex     : registered head-of-queue result
//   c_valid  : C_ex holds an unread result
//   c_ready  : consumer accepts C_ex this cycle
//   count    : entries currently held
//   full     : count == DEPTH
//   overflow : sticky, a result was dropped because the queue was full
//   clr_ovf  : clears overflow (a simultaneous drop wins)
module result_capture_fifo
  import result_capture_fifo_pkg::*;
#(
  parameter int WIDTH     = RSA_WIDTH,
  parameter int DEPTH     = RSA_DEPTH,
  parameter int HOLD_LAST = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       eoc,
  input  logic [WIDTH-1:0]           R_i,
  output logic [WIDTH-1:0]           C_ex,
  output logic                       c_valid,
  input  logic                       c_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [WIDTH-1:0] head_rd;
  logic [WIDTH-1:0] head_nxt;
  logic             push;
  logic             pop;
  logic             drop;
  logic             bypass;

  assign full = (count == CNT_W'(DEPTH));

  // The array is read at the post-update read pointer so that C_ex, being a
  // register, already shows the new head in the cycle after a pop.
  result_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we      (push),
    .wr_addr (wr_ptr),
    .wr_data (R_i),
    .rd_addr (rd_ptr_nxt),
    .rd_data (head_rd)
  );

  always_comb begin
    pop        = c_valid & c_ready;
    push       = en & eoc & (~full | pop);
    drop       = en & eoc & full & ~pop;
    rd_ptr_nxt = rd_ptr + AW'(pop);
    count_nxt  = count + CNT_W'(push) - CNT_W'(pop);
    // Queue is empty once the pop (if any) is taken: the pushed word becomes
    // the head directly, since the array write lands only at this edge.
    bypass     = push & (count == CNT_W'(pop));
    head_nxt   = head_rd;
    if (count_nxt == '0) begin
      head_nxt = (HOLD_LAST != 0) ? C_ex : '0;
    end else if (bypass) begin
      head_nxt = R_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      c_valid  <= 1'b0;
      C_ex     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      c_valid  <= (count_nxt != '0);
      C_ex     <= head_nxt;
      overflow <= drop | (overflow & ~clr_ovf);
    end
  end

endmodule

// File: tb/tb_result_capture_fifo.sv
module tb_result_capture_fifo;

  localparam int WIDTH = 10;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             eoc;
  logic [WIDTH-1:0] R_i;
  logic [WIDTH-1:0] C_ex;
  logic             c_valid;
  logic             c_ready;
  logic [2:0]       count;
  logic             full;
  logic             overflow;
  logic             clr_ovf;

  int n_vec = 0;
  int n_err = 0;

  result_capture_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .HOLD_LAST (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .eoc      (eoc),
    .R_i      (R_i),
    .C_ex     (C_ex),
    .c_valid  (c_valid),
    .c_ready  (c_ready),
    .count    (count),
    .full     (full),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst, en, eoc;
    logic [WIDTH-1:0] r;
    logic             rdy, clr;
    logic             v;
    logic [WIDTH-1:0] cex;
    logic [2:0]       cnt;
    logic             full, ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int i_rst, input int i_en, input int i_eoc, input int i_r,
                     input int i_rdy, input int i_clr, input int e_v, input int e_cex,
                     input int e_cnt, input int e_full, input int e_ovf);
    vec_t t;
    t.rst  = i_rst[0];
    t.en   = i_en[0];
    t.eoc  = i_eoc[0];
    t.r    = i_r[WIDTH-1:0];
    t.rdy  = i_rdy[0];
    t.clr  = i_clr[0];
    t.v    = e_v[0];
    t.cex  = e_cex[WIDTH-1:0];
    t.cnt  = e_cnt[2:0];
    t.full = e_full[0];
    t.ovf  = e_ovf[0];
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_v, input logic [WIDTH-1:0] e_cex,
                         input logic [2:0] e_cnt, input logic e_full, input logic e_ovf);
    chk({tag, ".c_valid"},  32'(c_valid),  32'(e_v));
    chk({tag, ".C_ex"},     32'(C_ex),     32'(e_cex));
    chk({tag, ".count"},    32'(count),    32'(e_cnt));
    chk({tag, ".full"},     32'(full),     32'(e_full));
    chk({tag, ".overflow"}, 32'(overflow), 32'(e_ovf));
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
  task automatic step(input logic i_rst, input logic i_en, input logic i_eoc,
                      input logic [WIDTH-1:0] i_r, input logic i_rdy, input logic i_clr);
    rst     = i_rst;
    en      = i_en;
    eoc     = i_eoc;
    R_i     = i_r;
    c_ready = i_rdy;
    clr_ovf = i_clr;
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  int               q[$];
  logic [WIDTH-1:0] m_last;
  logic             m_ovf;

  initial begin
    rst = 1'b1; en = 1'b0; eoc = 1'b0; R_i = '0; c_ready = 1'b0; clr_ovf = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all("reset", 1'b0, '0, 3'd0, 1'b0, 1'b0);

    //   rst en eoc R_i    rdy clr | v  C_ex   cnt full ovf
    add(0, 1, 1, 'h2A5, 0, 0,   1, 'h2A5, 1, 0, 0);  // single result
    add(0, 1, 0, 0,     1, 0,   0, 'h2A5, 0, 0, 0);  // pop, hold last
    add(0, 1, 1, 1,     0, 0,   1, 1,     1, 0, 0);  // burst
    add(0, 1, 1, 2,     0, 0,   1, 1,     2, 0, 0);
    add(0, 1, 1, 3,     0, 0,   1, 1,     3, 0, 0);
    add(0, 1, 1, 4,     0, 0,   1, 1,     4, 1, 0);
    add(0, 1, 1, 5,     0, 0,   1, 1,     4, 1, 1);  // dropped push
    add(0, 1, 1, 6,     0, 1,   1, 1,     4, 1, 1);  // drop beats clear
    add(0, 1, 0, 0,     0, 1,   1, 1,     4, 1, 0);  // clear alone
    add(0, 0, 1, 'h3FF, 0, 0,   1, 1,     4, 1, 0);  // en=0 ignores eoc
    add(0, 1, 1, 5,     1, 0,   1, 2,     4, 1, 0);  // full push+pop
    add(0, 0, 1, 'h3FF, 1, 0,   1, 3,     3, 0, 0);  // drain with en=0
    add(0, 1, 0, 0,     1, 0,   1, 4,     2, 0, 0);
    add(0, 1, 0, 0,     1, 0,   1, 5,     1, 0, 0);
    add(0, 1, 0, 0,     1, 0,   0, 5,     0, 0, 0);  // empty, hold 5
    add(0, 1, 0, 0,     1, 0,   0, 5,     0, 0, 0);  // ready while empty
    add(0, 1, 1, 'h0AB, 1, 0,   1, 'h0AB, 1, 0, 0);  // push into empty
    add(0, 1, 1, 'h0CD, 1, 0,   1, 'h0CD, 1, 0, 0);  // push+pop at count 1
    add(0, 1, 0, 0,     1, 0,   0, 'h0CD, 0, 0, 0);
    add(0, 1, 1, 'h111, 0, 0,   1, 'h111, 1, 0, 0);
    add(1, 1, 1, 'h077, 0, 0,   0, 0,     0, 0, 0);  // reset clears C_ex

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].eoc, tbl[i].r, tbl[i].rdy, tbl[i].clr);
      chk_all($sformatf("vec%0d", i), tbl[i].v, tbl[i].cex, tbl[i].cnt, tbl[i].full, tbl[i].ovf);
    end

    // Reset asserted for two cycles while three results are queued.
    step(0, 1, 1, 'h101, 0, 0);
    step(0, 1, 1, 'h102, 0, 0);
    step(0, 1, 1, 'h103, 0, 0);
    chk("midfill.count", 32'(count), 32'd3);
    chk("midfill.C_ex", 32'(C_ex), 32'h101);
    step(1, 1, 1, 'h104, 1, 0);
    step(1, 1, 1, 'h105, 1, 0);
    step(0, 1, 0, 'h000, 0, 0);
    chk_all("midrst", 1'b0, '0, 3'd0, 1'b0, 1'b0);

    // Randomised traffic against a queue-based model.
    q.delete();
    m_last = '0;
    m_ovf  = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic             r_rst, r_en, r_eoc, r_rdy, r_clr;
      logic [WIDTH-1:0] r_r;
      logic             m_pop, m_full, m_push, m_drop;
      r_rst = (i == 0) || ($urandom % 64 == 0);
      r_en  = ($urandom % 4) != 0;
      r_eoc = ($urandom % 2) != 0;
      r_r   = WIDTH'($urandom);
      r_rdy = ($urandom % 3) == 0;
      r_clr = ($urandom % 16) == 0;
      if (r_rst) begin
        q.delete();
        m_last = '0;
        m_ovf  = 1'b0;
      end else begin
        m_pop  = (q.size() > 0) && r_rdy;
        m_full = (q.size() == DEPTH);
        m_drop = r_en && r_eoc && m_full && !m_pop;
        m_push = r_en && r_eoc && (!m_full || m_pop);
        if (m_pop) m_last = WIDTH'(q.pop_front());
        if (m_push) q.push_back(int'(r_r));
        if (m_drop) m_ovf = 1'b1;
        else if (r_clr) m_ovf = 1'b0;
      end
      step(r_rst, r_en, r_eoc, r_r, r_rdy, r_clr);
      chk_all($sformatf("rnd%0d", i), q.size() > 0,
              (q.size() > 0) ? WIDTH'(q[0]) : m_last,
              3'(q.size()), q.size() == DEPTH, m_ovf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
